// File: rtl/keccak_block_padder.sv
// Keccak sponge absorb-block builder: packs a W-bit word stream into rate-sized blocks,
// applies the domain suffix and pad10*1 on the final block, and emits an extra pad-only block when needed.
module keccak_block_padder #(
  parameter int unsigned W        = 64,
  parameter int unsigned RATE_MAX = 1344
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [1:0]              mode,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [W-1:0]            in_data,
  input  logic [$clog2(W/8):0]    in_bytes,
  input  logic                    in_last,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RATE_MAX-1:0]     out_block,
  output logic                    out_last
);

  localparam int unsigned BW  = W / 8;
  localparam int unsigned NB  = RATE_MAX / 8;
  localparam int unsigned PW  = $clog2(NB + 1);
  localparam int unsigned IBW = $clog2(BW) + 1;

  typedef enum logic [1:0] {FILL, EMIT, EMIT_PAD} state_e;

  function automatic logic [PW-1:0] rate_bytes_of(input logic [1:0] m);
    case (m)
      2'd0:       return PW'(168);
      2'd1, 2'd2: return PW'(136);
      default:    return PW'(72);
    endcase
  endfunction

  function automatic logic [7:0] sfx_of(input logic [1:0] m);
    return m[1] ? 8'h06 : 8'h1F;
  endfunction

  state_e              state_q, state_d;
  logic [RATE_MAX-1:0] buf_q, buf_d;
  logic [PW-1:0]       count_q, count_d;
  logic [1:0]          mode_q, mode_d;
  logic                out_valid_q, out_valid_d;
  logic                out_last_q, out_last_d;

  logic [1:0]          mode_eff;
  logic [PW-1:0]       rb, rw, rb_q, pos, count_inc;
  logic [7:0]          sfx, sfx_q;
  logic [IBW-1:0]      nb;
  logic [W-1:0]        masked;
  logic [RATE_MAX-1:0] placed;
  int unsigned         shamt;

  always_comb begin
    state_d     = state_q;
    buf_d       = buf_q;
    count_d     = count_q;
    mode_d      = mode_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;

    in_ready  = rst_n && (state_q == FILL);
    // the live mode input only matters on the first word of a block-fill
    mode_eff  = (count_q == '0) ? mode : mode_q;
    rb        = rate_bytes_of(mode_eff);
    rw        = rb / PW'(BW);
    sfx       = sfx_of(mode_eff);
    rb_q      = rate_bytes_of(mode_q);
    sfx_q     = sfx_of(mode_q);
    count_inc = count_q + PW'(1);

    nb = (in_bytes > IBW'(BW)) ? IBW'(BW) : in_bytes;
    masked = '0;
    for (int unsigned j = 0; j < BW; j++) begin
      if (!in_last || (IBW'(j) < nb)) masked[8*j +: 8] = in_data[8*j +: 8];
    end
    pos    = count_q * PW'(BW) + PW'(nb);
    shamt  = 32'(count_q) * W;
    placed = RATE_MAX'(masked) << shamt;

    case (state_q)
      FILL: begin
        if (in_valid && in_ready) begin
          mode_d = mode_eff;
          buf_d  = buf_q | placed;
          if (!in_last) begin
            count_d = count_inc;
            if (count_inc == rw) begin
              out_valid_d = 1'b1;
              out_last_d  = 1'b0;
              state_d     = EMIT;
            end
          end else if (pos == rb) begin
            // message ends exactly on the boundary; count stays non-zero so mode_q is kept
            count_d     = count_inc;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            state_d     = EMIT_PAD;
          end else begin
            for (int unsigned b = 0; b < NB; b++) begin
              if (PW'(b) == pos)            buf_d[8*b +: 8] = buf_d[8*b +: 8] ^ sfx;
              if (PW'(b) == rb - PW'(1))    buf_d[8*b +: 8] = buf_d[8*b +: 8] ^ 8'h80;
            end
            out_valid_d = 1'b1;
            out_last_d  = 1'b1;
            state_d     = EMIT;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          buf_d       = '0;
          count_d     = '0;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = FILL;
        end
      end
      EMIT_PAD: begin
        if (out_ready) begin
          buf_d       = '0;
          buf_d[7:0]  = sfx_q;
          for (int unsigned b = 0; b < NB; b++) begin
            if (PW'(b) == rb_q - PW'(1)) buf_d[8*b +: 8] = buf_d[8*b +: 8] ^ 8'h80;
          end
          count_d     = '0;
          out_valid_d = 1'b1;
          out_last_d  = 1'b1;
          state_d     = EMIT;
        end
      end
      default: state_d = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      buf_q       <= '0;
      count_q     <= '0;
      mode_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      count_q     <= count_d;
      mode_q      <= mode_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
    end
  end

  assign out_block = buf_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;

endmodule
